// File: rtl/adv7611_cfg_pkg.sv
// Shared types and constants for the ADV7611 configuration sequencer.
package adv7611_cfg_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HOLD = 3'd1,
      S_RUN  = 3'd2,
      S_DONE = 3'd3,
      S_FAIL = 3'd4
   } cfg_state_t;

   // Cycles after controller release during which its done flag is not trusted
   localparam int unsigned SETTLE_CYCLES = 4;

   // {ID_addr, reg_addr, reg_data}
   typedef logic [23:0] lut_entry_t;

endpackage

// File: rtl/adv7611_cfg_lut.sv
// ADV7611 register write table: registered lookup of {ID_addr, reg_addr, reg_data}.
module adv7611_cfg_lut
   import adv7611_cfg_pkg::*;
#(
   parameter logic [7:0] CFG_SIZE = 8'd64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] idx,
   output lut_entry_t data
);

   function automatic lut_entry_t lut_word(input logic [7:0] i);
      lut_entry_t w;
      case (i)
         // IO map: slave map addresses, then video mode and output format
         8'd0:  w = 24'h98F480;
         8'd1:  w = 24'h98F57C;
         8'd2:  w = 24'h98F84C;
         8'd3:  w = 24'h98F964;
         8'd4:  w = 24'h98FA6C;
         8'd5:  w = 24'h98FB68;
         8'd6:  w = 24'h98FD44;
         8'd7:  w = 24'h980105;
         8'd8:  w = 24'h980019;
         8'd9:  w = 24'h9802F5;
         8'd10: w = 24'h980380;
         8'd11: w = 24'h980462;
         8'd12: w = 24'h980528;
         8'd13: w = 24'h9806A6;
         8'd14: w = 24'h980B44;
         8'd15: w = 24'h980C42;
         8'd16: w = 24'h98147F;
         8'd17: w = 24'h981580;
         8'd18: w = 24'h981983;
         8'd19: w = 24'h983340;
         8'd20: w = 24'h44BA01;
         8'd21: w = 24'h644081;
         // HDMI map: equaliser, TMDS and audio setup
         8'd22: w = 24'h689B03;
         8'd23: w = 24'h68C101;
         8'd24: w = 24'h68C201;
         8'd25: w = 24'h68C301;
         8'd26: w = 24'h68C401;
         8'd27: w = 24'h68C501;
         8'd28: w = 24'h68C601;
         8'd29: w = 24'h68C701;
         8'd30: w = 24'h68C801;
         8'd31: w = 24'h68C901;
         8'd32: w = 24'h68CA01;
         8'd33: w = 24'h68CB01;
         8'd34: w = 24'h68CC01;
         8'd35: w = 24'h680008;
         8'd36: w = 24'h680203;
         8'd37: w = 24'h680398;
         8'd38: w = 24'h6810A5;
         8'd39: w = 24'h681B08;
         8'd40: w = 24'h684504;
         8'd41: w = 24'h6897C0;
         8'd42: w = 24'h683D10;
         8'd43: w = 24'h683E69;
         8'd44: w = 24'h683F46;
         8'd45: w = 24'h684EFE;
         8'd46: w = 24'h684F08;
         8'd47: w = 24'h685000;
         8'd48: w = 24'h6857A3;
         8'd49: w = 24'h685807;
         8'd50: w = 24'h686F08;
         8'd51: w = 24'h6883FE;
         8'd52: w = 24'h68869B;
         8'd53: w = 24'h688510;
         8'd54: w = 24'h688901;
         8'd55: w = 24'h689B03;
         8'd56: w = 24'h689303;
         8'd57: w = 24'h685A80;
         8'd58: w = 24'h686C54;
         8'd59: w = 24'h687510;
         8'd60: w = 24'h688D04;
         8'd61: w = 24'h688E1E;
         // Finally assert HPD towards the source
         8'd62: w = 24'h982070;
         8'd63: w = 24'h9820F8;
         default: w = 24'h000000;
      endcase
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data <= '0;
      end else if (idx < CFG_SIZE) begin
         data <= lut_word(idx);
      end else begin
         data <= '0;
      end
   end

endmodule

// File: rtl/adv7611_cfg_sequencer.sv
// Drives the ADV7611 I2C controller: reset hold, timed run with retries,
// HPD-debounced and software-triggered restarts, and status reporting.
module adv7611_cfg_sequencer
   import adv7611_cfg_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 100_000000,
   parameter logic [7:0]  CFG_SIZE    = 8'd64,
   parameter int unsigned HOLD_US     = 10,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned TIMEOUT_MS  = 500,
   parameter int unsigned MAX_TRY     = 3,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hdmi_hpd,
   input  logic        cfg_start,
   output logic        ctrl_rst_n,
   output logic [7:0]  i2c_config_size,
   input  logic [7:0]  i2c_config_index,
   output logic [23:0] i2c_config_data,
   input  logic        i2c_config_done,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_fail,
   output logic [7:0]  cfg_count
);

   localparam logic [15:0] HOLD_CYCLES = 16'(CLK_FREQ / 1_000_000 * HOLD_US);
   localparam logic [31:0] DEB_CYCLES  = 32'(CLK_FREQ / 1000 * DEBOUNCE_MS);
   localparam logic [31:0] TO_CYCLES   = 32'(CLK_FREQ / 1000 * TIMEOUT_MS);
   localparam logic [31:0] SETTLE      = 32'(SETTLE_CYCLES);
   localparam logic [7:0]  MAX_TRY_W   = 8'(MAX_TRY);

   logic        hpd_meta, hpd_sync, hpd_level, hpd_rise;
   logic [31:0] deb_cnt;
   logic        first_cycle;
   logic        trigger;

   cfg_state_t  state, state_next;
   logic [15:0] hold_cnt;
   logic [31:0] run_cnt;
   logic [7:0]  try_cnt;
   logic        try_load, try_inc, pass_ok;

   assign i2c_config_size = CFG_SIZE;

   adv7611_cfg_lut #(.CFG_SIZE(CFG_SIZE)) u_lut (
      .clk  (clk),
      .rst_n(rst_n),
      .idx  (i2c_config_index),
      .data (i2c_config_data)
   );

   // The debounced level only follows the synchronised input after a full
   // stable window; returning to the current level restarts the window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hpd_meta  <= 1'b0;
         hpd_sync  <= 1'b0;
         hpd_level <= 1'b0;
         hpd_rise  <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         hpd_meta <= hdmi_hpd;
         hpd_sync <= hpd_meta;
         hpd_rise <= 1'b0;
         if (hpd_sync == hpd_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_CYCLES - 32'd1) begin
            deb_cnt   <= '0;
            hpd_level <= hpd_sync;
            hpd_rise  <= hpd_sync;
         end else begin
            deb_cnt <= deb_cnt + 32'd1;
         end
      end
   end

   assign trigger = cfg_start | hpd_rise | (AUTO_START & first_cycle);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      try_load   = 1'b0;
      try_inc    = 1'b0;
      pass_ok    = 1'b0;
      ctrl_rst_n = 1'b0;
      cfg_busy   = 1'b0;
      cfg_done   = 1'b0;
      cfg_fail   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (trigger) begin
               try_load   = 1'b1;
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            cfg_busy = 1'b1;
            if (hold_cnt == HOLD_CYCLES - 16'd1) begin
               state_next = S_RUN;
            end
         end
         // A trigger beats a simultaneous done so an aborted pass is never counted
         S_RUN: begin
            ctrl_rst_n = 1'b1;
            cfg_busy   = 1'b1;
            if (trigger) begin
               try_load   = 1'b1;
               state_next = S_HOLD;
            end else if (i2c_config_done && run_cnt >= SETTLE) begin
               pass_ok    = 1'b1;
               state_next = S_DONE;
            end else if (run_cnt == TO_CYCLES - 32'd1) begin
               if (try_cnt < MAX_TRY_W) begin
                  try_inc    = 1'b1;
                  state_next = S_HOLD;
               end else begin
                  state_next = S_FAIL;
               end
            end
         end
         S_DONE: begin
            ctrl_rst_n = 1'b1;
            cfg_done   = 1'b1;
            if (trigger) begin
               try_load   = 1'b1;
               state_next = S_HOLD;
            end
         end
         S_FAIL: begin
            cfg_fail = 1'b1;
            if (trigger) begin
               try_load   = 1'b1;
               state_next = S_HOLD;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Hold and run timers restart from zero on every entry into their state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         first_cycle <= 1'b1;
         hold_cnt    <= '0;
         run_cnt     <= '0;
         try_cnt     <= '0;
         cfg_count   <= '0;
      end else begin
         first_cycle <= 1'b0;
         hold_cnt    <= (state == S_HOLD && state_next == S_HOLD) ? hold_cnt + 16'd1 : 16'd0;
         run_cnt     <= (state == S_RUN && state_next == S_RUN) ? run_cnt + 32'd1 : 32'd0;
         if (try_load) begin
            try_cnt <= 8'd1;
         end else if (try_inc) begin
            try_cnt <= try_cnt + 8'd1;
         end
         if (pass_ok && cfg_count != 8'hFF) begin
            cfg_count <= cfg_count + 8'd1;
         end
      end
   end

endmodule
